// File: rtl/apb_i2c_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_i2c_regs_pkg
//  Description : Shared register offsets, bit indices, sequencer state
//                encodings and the STATUS layout for the APB I2C front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_i2c_regs_pkg;

  // Register byte offsets (bits [1:0] of PADDR are ignored)
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_ADDR   = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_LEN    = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  // CTRL bit indices
  localparam int CTRL_EN    = 0;
  localparam int CTRL_RW    = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_FLUSH = 3;

  // Sticky STATUS bit indices (write-1-to-clear)
  localparam int ST_DONE = 1;
  localparam int ST_NACK = 2;
  localparam int ST_OVF  = 3;

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  // STATUS register layout, MSB first
  typedef struct packed {
    logic rx_empty;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
    logic rx_ovf;
    logic nack;
    logic done;
    logic busy;
  } status_t;

endpackage
`default_nettype wire

// File: rtl/apb_i2c_regs_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock byte FIFO with flush. Push on full and pop on
//                empty are ignored; full/empty reflect the pre-edge state.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; flush overrides any same-cycle push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/apb_i2c_regs.sv
`default_nettype none
// ============================================================================
//  Module      : apb_i2c_regs
//  Description : APB3 register front-end for i2c_core: CTRL/ADDR/LEN/STATUS,
//                TX and RX byte FIFOs, and the transfer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_i2c_regs
  import apb_i2c_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              core_enable,
  output logic [6:0]        core_slave_address,
  output logic [7:0]        core_data_in,
  output logic              core_rw,
  input  logic              core_data_req,
  input  logic [7:0]        core_data_out,
  input  logic              core_data_valid,
  input  logic              core_nack,
  input  logic              core_busy
);

  // ---------------- APB decode ----------------
  logic [ADDR_W-1:0] reg_addr;
  logic access, wr_acc, rd_acc;
  logic sel_ctrl, sel_addr, sel_tx, sel_rx, sel_len, sel_status, sel_any;

  assign reg_addr   = paddr & ~ADDR_W'(3);
  assign access     = psel & penable;
  assign wr_acc     = access & pwrite;
  assign rd_acc     = access & ~pwrite;
  assign sel_ctrl   = (reg_addr == ADDR_W'(OFF_CTRL));
  assign sel_addr   = (reg_addr == ADDR_W'(OFF_ADDR));
  assign sel_tx     = (reg_addr == ADDR_W'(OFF_TXDATA));
  assign sel_rx     = (reg_addr == ADDR_W'(OFF_RXDATA));
  assign sel_len    = (reg_addr == ADDR_W'(OFF_LEN));
  assign sel_status = (reg_addr == ADDR_W'(OFF_STATUS));
  assign sel_any    = sel_ctrl | sel_addr | sel_tx | sel_rx | sel_len | sel_status;

  // ---------------- State ----------------
  logic [1:0] state_q, state_d;
  logic       en_q, en_d, rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic       done_q, done_d, nack_q, nack_d, ovf_q, ovf_d;
  logic       core_enable_q, core_enable_d;
  logic [6:0] core_slave_address_q, core_slave_address_d;
  logic [7:0] core_data_in_q, core_data_in_d;
  logic       core_rw_q, core_rw_d;
  logic [7:0] rx_rem_q, rx_rem_d;

  // ---------------- FIFOs ----------------
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic       tx_push, tx_pop, rx_push, rx_pop, flush;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (tx_push),
    .push_data (pwdata),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (rx_push),
    .push_data (core_data_out),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // ---------------- Access qualification ----------------
  // START is judged on the EN/RW values carried by the same write, so a
  // single CTRL write can both enable and launch a transfer.
  logic start_req, start_ok, start_err, ctrl_we, err;

  assign start_req = wr_acc & sel_ctrl & pwdata[CTRL_START];
  assign start_ok  = start_req & (state_q == S_IDLE) & pwdata[CTRL_EN]
                   & (pwdata[CTRL_RW] | ~tx_empty);
  assign start_err = start_req & ~start_ok;
  assign ctrl_we   = wr_acc & sel_ctrl & ~start_err;
  assign flush     = ctrl_we & pwdata[CTRL_FLUSH];
  assign tx_push   = wr_acc & sel_tx & ~tx_full;
  assign rx_pop    = rd_acc & sel_rx & ~rx_empty;

  assign err = access & (~sel_any
                         | (pwrite & sel_rx)
                         | (~pwrite & sel_tx)
                         | (pwrite & sel_tx & tx_full)
                         | (~pwrite & sel_rx & rx_empty)
                         | start_err);

  status_t status;
  always_comb begin
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_empty = tx_empty;
    status.tx_full  = tx_full;
    status.rx_ovf   = ovf_q;
    status.nack     = nack_q;
    status.done     = done_q;
    status.busy     = (state_q != S_IDLE);
  end

  // Combinational read mux and error response during the access cycle
  always_comb begin
    prdata  = 8'h00;
    pslverr = err;
    if (rd_acc && !err) begin
      if (sel_ctrl)   prdata = {6'b0, rw_q, en_q};
      if (sel_addr)   prdata = {1'b0, addr_q};
      if (sel_rx)     prdata = rx_head;
      if (sel_len)    prdata = len_q;
      if (sel_status) prdata = status;
    end
  end

  assign pready = 1'b1;

  // ---------------- Sequencer ----------------
  logic set_done, set_nack, set_ovf;

  // Transfer sequencer: launches on START, feeds/collects bytes, waits bus idle
  always_comb begin
    state_d              = state_q;
    core_slave_address_d = core_slave_address_q;
    core_rw_d            = core_rw_q;
    core_data_in_d       = core_data_in_q;
    rx_rem_d             = rx_rem_q;
    tx_pop               = 1'b0;
    rx_push              = 1'b0;
    set_done             = 1'b0;
    set_nack             = 1'b0;
    set_ovf              = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d              = S_LOAD;
          core_slave_address_d = addr_q;
          core_rw_d            = pwdata[CTRL_RW];
          rx_rem_d             = (len_q == 8'd0) ? 8'd1 : len_q;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        if (!core_rw_q) begin
          // A FLUSH issued with START can leave nothing to send
          if (tx_empty) begin
            state_d = S_STOP;
          end else begin
            tx_pop         = 1'b1;
            core_data_in_d = tx_head;
          end
        end
      end
      S_RUN: begin
        if (core_nack) begin
          set_nack = 1'b1;
          state_d  = S_STOP;
        end else if (!en_q) begin
          state_d = S_STOP;
        end else if (!core_rw_q) begin
          if (core_data_req) begin
            if (tx_empty) begin
              state_d = S_STOP;
            end else begin
              tx_pop         = 1'b1;
              core_data_in_d = tx_head;
            end
          end
        end else if (core_data_valid) begin
          if (rx_full) set_ovf = 1'b1;
          else         rx_push = 1'b1;
          rx_rem_d = rx_rem_q - 8'd1;
          if (rx_rem_q == 8'd1) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!core_busy) begin
          state_d  = S_IDLE;
          set_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    core_enable_d = (state_d == S_RUN);
  end

  // Software-visible registers; hardware set of sticky bits beats W1C
  always_comb begin
    en_d   = en_q;
    rw_d   = rw_q;
    addr_d = addr_q;
    len_d  = len_q;
    done_d = done_q;
    nack_d = nack_q;
    ovf_d  = ovf_q;
    if (ctrl_we) begin
      en_d = pwdata[CTRL_EN];
      rw_d = pwdata[CTRL_RW];
    end
    if (wr_acc && sel_addr) addr_d = pwdata[6:0];
    if (wr_acc && sel_len)  len_d  = pwdata;
    if (wr_acc && sel_status) begin
      done_d = done_q & ~pwdata[ST_DONE];
      nack_d = nack_q & ~pwdata[ST_NACK];
      ovf_d  = ovf_q  & ~pwdata[ST_OVF];
    end
    if (set_done) done_d = 1'b1;
    if (set_nack) nack_d = 1'b1;
    if (set_ovf)  ovf_d  = 1'b1;
  end

  // All flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_IDLE;
      en_q                 <= 1'b0;
      rw_q                 <= 1'b0;
      addr_q               <= '0;
      len_q                <= '0;
      done_q               <= 1'b0;
      nack_q               <= 1'b0;
      ovf_q                <= 1'b0;
      core_enable_q        <= 1'b0;
      core_slave_address_q <= '0;
      core_data_in_q       <= '0;
      core_rw_q            <= 1'b0;
      rx_rem_q             <= '0;
    end else begin
      state_q              <= state_d;
      en_q                 <= en_d;
      rw_q                 <= rw_d;
      addr_q               <= addr_d;
      len_q                <= len_d;
      done_q               <= done_d;
      nack_q               <= nack_d;
      ovf_q                <= ovf_d;
      core_enable_q        <= core_enable_d;
      core_slave_address_q <= core_slave_address_d;
      core_data_in_q       <= core_data_in_d;
      core_rw_q            <= core_rw_d;
      rx_rem_q             <= rx_rem_d;
    end
  end

  assign core_enable        = core_enable_q;
  assign core_slave_address = core_slave_address_q;
  assign core_data_in       = core_data_in_q;
  assign core_rw            = core_rw_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_i2c_regs
//  Description : Scoreboard bench for apb_i2c_regs with a simple i2c_core
//                stand-in driven by directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_i2c_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       core_enable, core_rw;
  logic [6:0] core_slave_address;
  logic [7:0] core_data_in;
  logic       core_data_req = 1'b0, core_data_valid = 1'b0;
  logic       core_nack = 1'b0, core_busy = 1'b0;
  logic [7:0] core_data_out = 8'h00;

  always #5 clk = ~clk;

  apb_i2c_regs #(.FIFO_DEPTH(8), .ADDR_W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .psel               (psel),
    .penable            (penable),
    .pwrite             (pwrite),
    .paddr              (paddr),
    .pwdata             (pwdata),
    .prdata             (prdata),
    .pready             (pready),
    .pslverr            (pslverr),
    .core_enable        (core_enable),
    .core_slave_address (core_slave_address),
    .core_data_in       (core_data_in),
    .core_rw            (core_rw),
    .core_data_req      (core_data_req),
    .core_data_out      (core_data_out),
    .core_data_valid    (core_data_valid),
    .core_nack          (core_nack),
    .core_busy          (core_busy)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] rd;
    logic       err;
  } apb_exp_t;

  apb_exp_t   exp_q[$];
  logic [7:0] tx_exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  // Monitor: APB responses and bytes handed to the core on each data_req
  always @(negedge clk) begin : mon
    apb_exp_t   e;
    logic [7:0] b;
    if (psel && penable) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL apb_unexpected addr=%h got prdata=%h pslverr=%b required none", paddr, prdata, pslverr);
      end else begin
        e = exp_q.pop_front();
        if (pslverr !== e.err || pready !== 1'b1 || (!e.wr && prdata !== e.rd)) begin
          n_miss++;
          $display("FAIL apb_%s addr=%h got prdata=%h pslverr=%b pready=%b required prdata=%h pslverr=%b pready=1",
                   e.wr ? "wr" : "rd", e.addr, prdata, pslverr, pready, e.rd, e.err);
        end
      end
    end
    if (core_data_req) begin
      n_vec++;
      if (tx_exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL core_data_in unexpected req got %h", core_data_in);
      end else begin
        b = tx_exp_q.pop_front();
        if (core_data_in !== b) begin
          n_miss++;
          $display("FAIL core_data_in got %h required %h", core_data_in, b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input logic exp_err);
    apb_exp_t e;
    e.wr = wr; e.addr = a; e.rd = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic err);
    apb(1'b1, a, d, 8'h00, err);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic err);
    apb(1'b0, a, 8'h00, exp, err);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req;
    @(posedge clk); #1 core_data_req = 1'b1;
    @(posedge clk); #1 core_data_req = 1'b0;
  endtask

  task automatic pulse_valid(input logic [7:0] d);
    @(posedge clk); #1 core_data_valid = 1'b1; core_data_out = d;
    @(posedge clk); #1 core_data_valid = 1'b0;
  endtask

  task automatic pulse_nack;
    @(posedge clk); #1 core_nack = 1'b1;
    @(posedge clk); #1 core_nack = 1'b0;
  endtask

  task automatic wait_enable(input string name);
    int i;
    i = 0;
    while (core_enable !== 1'b1 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check(name, {7'b0, core_enable}, 8'h01);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_enable", {7'b0, core_enable}, 8'h00);
    check("rst_core_addr",   {1'b0, core_slave_address}, 8'h00);
    check("rst_core_data",   core_data_in, 8'h00);
    check("rst_core_rw",     {7'b0, core_rw}, 8'h00);
    check("rst_prdata",      prdata, 8'h00);
    rst = 1'b0;
    rd(8'h14, 8'hA0, 1'b0);
    rd(8'h00, 8'h00, 1'b0);

    // 2: two-byte write
    wr(8'h08, 8'h33, 1'b0);
    wr(8'h08, 8'hDA, 1'b0);
    wr(8'h04, 8'h01, 1'b0);
    rd(8'h14, 8'h80, 1'b0);
    tx_exp_q.push_back(8'h33);
    tx_exp_q.push_back(8'hDA);
    wr(8'h00, 8'h05, 1'b0);
    wait_enable("wr_enable");
    core_busy = 1'b1;
    check("wr_slave_addr", {1'b0, core_slave_address}, 8'h01);
    check("wr_core_rw",    {7'b0, core_rw}, 8'h00);
    rd(8'h14, 8'h81, 1'b0);
    pulse_req();
    idle(2);
    check("wr_enable_mid", {7'b0, core_enable}, 8'h01);
    pulse_req();
    check("wr_enable_drop", {7'b0, core_enable}, 8'h00);
    rd(8'h14, 8'hA1, 1'b0);
    core_busy = 1'b0;
    idle(2);
    rd(8'h14, 8'hA2, 1'b0);
    wr(8'h14, 8'h02, 1'b0);
    rd(8'h14, 8'hA0, 1'b0);

    // 3: two-byte read
    wr(8'h10, 8'h02, 1'b0);
    wr(8'h00, 8'h07, 1'b0);
    wait_enable("rd_enable");
    core_busy = 1'b1;
    check("rd_core_rw", {7'b0, core_rw}, 8'h01);
    pulse_valid(8'h5A);
    idle(1);
    pulse_valid(8'hC3);
    check("rd_enable_drop", {7'b0, core_enable}, 8'h00);
    core_busy = 1'b0;
    idle(2);
    rd(8'h14, 8'h22, 1'b0);
    rd(8'h0C, 8'h5A, 1'b0);
    rd(8'h0C, 8'hC3, 1'b0);
    rd(8'h0C, 8'h00, 1'b1);
    wr(8'h14, 8'h02, 1'b0);

    // illegal accesses
    rd(8'h18, 8'h00, 1'b1);
    wr(8'h0C, 8'h11, 1'b1);
    rd(8'h08, 8'h00, 1'b1);

    // 4: TX full, RX overflow
    for (int i = 0; i < 8; i++) wr(8'h08, 8'h10 + 8'(i), 1'b0);
    wr(8'h08, 8'hFF, 1'b1);
    rd(8'h14, 8'h90, 1'b0);
    wr(8'h10, 8'h09, 1'b0);
    wr(8'h00, 8'h07, 1'b0);
    wait_enable("ovf_enable");
    core_busy = 1'b1;
    for (int i = 0; i < 9; i++) pulse_valid(8'h40 + 8'(i));
    check("ovf_enable_drop", {7'b0, core_enable}, 8'h00);
    core_busy = 1'b0;
    idle(2);
    rd(8'h14, 8'h5A, 1'b0);
    wr(8'h14, 8'h08, 1'b0);
    rd(8'h14, 8'h52, 1'b0);
    rd(8'h0C, 8'h40, 1'b0);
    wr(8'h00, 8'h09, 1'b0);
    rd(8'h14, 8'hA2, 1'b0);
    wr(8'h14, 8'h02, 1'b0);

    // 5: NACK mid-write, START while busy
    wr(8'h08, 8'h71, 1'b0);
    wr(8'h08, 8'h72, 1'b0);
    wr(8'h08, 8'h73, 1'b0);
    tx_exp_q.push_back(8'h71);
    wr(8'h00, 8'h05, 1'b0);
    wait_enable("nack_enable");
    core_busy = 1'b1;
    pulse_req();
    wr(8'h00, 8'h05, 1'b1);
    rd(8'h14, 8'h81, 1'b0);
    check("busy_start_enable", {7'b0, core_enable}, 8'h01);
    check("busy_start_data", core_data_in, 8'h72);
    pulse_nack();
    check("nack_enable_drop", {7'b0, core_enable}, 8'h00);
    rd(8'h14, 8'h85, 1'b0);
    core_busy = 1'b0;
    idle(2);
    rd(8'h14, 8'h86, 1'b0);
    wr(8'h14, 8'h06, 1'b0);
    rd(8'h14, 8'h80, 1'b0);
    wr(8'h00, 8'h09, 1'b0);
    wr(8'h00, 8'h04, 1'b1);
    rd(8'h00, 8'h01, 1'b0);
    rd(8'h14, 8'hA0, 1'b0);

    // 6: reset during RUN
    wr(8'h04, 8'h2B, 1'b0);
    wr(8'h08, 8'h55, 1'b0);
    wr(8'h08, 8'h66, 1'b0);
    wr(8'h00, 8'h05, 1'b0);
    wait_enable("rst_run_enable");
    core_busy = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstrun_enable", {7'b0, core_enable}, 8'h00);
    check("rstrun_addr",   {1'b0, core_slave_address}, 8'h00);
    check("rstrun_data",   core_data_in, 8'h00);
    check("rstrun_rw",     {7'b0, core_rw}, 8'h00);
    rst = 1'b0;
    core_busy = 1'b0;
    rd(8'h14, 8'hA0, 1'b0);
    rd(8'h00, 8'h00, 1'b0);
    rd(8'h04, 8'h00, 1'b0);

    idle(2);
    check("apb_queue_left", 8'(exp_q.size()), 8'h00);
    check("tx_queue_left",  8'(tx_exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
